// File: rtl/cpu_pkg.sv
// Shared CPU types: load-size encoding and the writeback retire-buffer entry.
// Entry fields are sized for the widest configuration; users slice down to XLEN/AW.
package cpu_pkg;

  localparam int WB_XLEN_MAX       = 64;
  localparam int WB_AW_MAX         = 8;
  localparam int WB_RA_IDX_DEFAULT = 15;

  typedef enum logic [1:0] {
    WB_LD_BYTE  = 2'b00,
    WB_LD_HALF  = 2'b01,
    WB_LD_WORD  = 2'b10,
    WB_LD_DWORD = 2'b11
  } wb_ld_size_e;

  typedef struct packed {
    logic                   wen;
    logic [WB_AW_MAX-1:0]   addr;
    logic [WB_XLEN_MAX-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_ld_align.sv
// Load formatter: picks byte/half/word/dword from the raw read word by offset, then sign/zero-extends.
// Purely combinational, no backpressure.
module wb_ld_align
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wb_ld_size_e       size,
  input  logic              uns,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   raw,
  output logic [XLEN-1:0]   data
);

  logic [63:0] raw64;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;
  logic [63:0] ext;
  logic        unused_ext;

  assign raw64 = 64'(raw);
  assign b     = raw64[{off, 3'b000} +: 8];
  assign h     = raw64[{off[1], 4'b0000} +: 16];
  assign w     = raw64[31:0];

  always_comb begin
    ext = '0;
    case (size)
      WB_LD_BYTE: ext = {{56{b[7] & ~uns}}, b};
      WB_LD_HALF: ext = {{48{h[15] & ~uns}}, h};
      WB_LD_WORD: ext = {{32{w[31] & ~uns}}, w};
      // dword only exists on 64-bit datapaths; a 32-bit core sees it as a word
      WB_LD_DWORD: ext = (XLEN == 64) ? raw64 : {{32{w[31] & ~uns}}, w};
      default: ext = '0;
    endcase
  end

  assign data       = ext[XLEN-1:0];
  assign unused_ext = ^ext;

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback stage: formats MA results into an in-order retire FIFO drained to the RF write port.
// Entry visible to the RF one cycle after accept; RF backpressure via rf_wr_rdy, MA stalls when full.
module wb_retire_stage
  import cpu_pkg::*;
#(
  parameter  int XLEN        = 32,
  parameter  int NREG        = 16,
  parameter  int RA_IDX      = NREG - 1,
  parameter  int DEPTH       = 2,
  parameter  int ZERO_REG_EN = 0,
  parameter  int CNT_W       = 32,
  localparam int AW          = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ma_wb_vld,
  output logic             ma_wb_rdy,
  input  logic [XLEN-1:0]  ma_wb_pc,
  input  logic [AW-1:0]    ma_wb_rd,
  input  logic [XLEN-1:0]  ma_wb_alu_result,
  input  logic [XLEN-1:0]  ma_wb_ld_data,
  input  logic             ma_wb_is_wb,
  input  logic             ma_wb_is_ld,
  input  logic             ma_wb_is_call,
  input  logic [1:0]       ma_wb_ld_size,
  input  logic             ma_wb_ld_uns,
  output logic             rf_wr_en,
  input  logic             rf_wr_rdy,
  output logic [AW-1:0]    rf_wr_addr,
  output logic [XLEN-1:0]  rf_wr_data,
  input  logic [AW-1:0]    fwd_q_addr,
  output logic             fwd_hit,
  output logic [XLEN-1:0]  fwd_data,
  output logic             retire_pulse,
  output logic [CNT_W-1:0] instret
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] instret_q;
  logic [XLEN-1:0]  ld_val;
  logic [AW-1:0]    new_addr;
  wb_entry_t        new_entry;
  logic             push, pop, active, head_wen;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  wb_ld_align #(.XLEN(XLEN)) u_ld_align (
    .size (wb_ld_size_e'(ma_wb_ld_size)),
    .uns  (ma_wb_ld_uns),
    .off  (ma_wb_alu_result[1:0]),
    .raw  (ma_wb_ld_data),
    .data (ld_val)
  );

  assign ma_wb_rdy = start && (count < CW'(DEPTH));
  assign push      = ma_wb_vld && ma_wb_rdy;
  assign new_addr  = ma_wb_is_call ? AW'(RA_IDX) : ma_wb_rd;

  always_comb begin
    new_entry      = '0;
    new_entry.addr = WB_AW_MAX'(new_addr);
    new_entry.wen  = (ma_wb_is_wb || ma_wb_is_call) && !((ZERO_REG_EN != 0) && (new_addr == '0));
    if (ma_wb_is_call)
      new_entry.data = WB_XLEN_MAX'(ma_wb_pc + XLEN'(4));
    else if (ma_wb_is_ld)
      new_entry.data = WB_XLEN_MAX'(ld_val);
    else
      new_entry.data = WB_XLEN_MAX'(ma_wb_alu_result);
  end

  // Reset masks the head so a discarded entry can never reach the register file
  assign active       = !rst && (count != '0);
  assign head_wen     = mem[rd_ptr].wen;
  assign rf_wr_en     = active && head_wen;
  assign rf_wr_addr   = active ? mem[rd_ptr].addr[AW-1:0] : '0;
  assign rf_wr_data   = active ? mem[rd_ptr].data[XLEN-1:0] : '0;
  assign pop          = active && (!head_wen || rf_wr_rdy);
  assign retire_pulse = pop;
  assign instret      = rst ? '0 : instret_q;

  // Walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && (CW'(i) < count) &&
          mem[PW'((int'(rd_ptr) + i) % DEPTH)].wen &&
          (mem[PW'((int'(rd_ptr) + i) % DEPTH)].addr[AW-1:0] == fwd_q_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem[PW'((int'(rd_ptr) + i) % DEPTH)].data[XLEN-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      instret_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      instret_q <= instret_q + CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Randomized bench for wb_retire_stage with a queue-based reference model and directed literal checks.
module tb_wb_retire_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, start, ma_wb_vld, ma_wb_rdy;
  logic [31:0] ma_wb_pc, ma_wb_alu_result, ma_wb_ld_data;
  logic [3:0]  ma_wb_rd, rf_wr_addr, fwd_q_addr;
  logic        ma_wb_is_wb, ma_wb_is_ld, ma_wb_is_call, ma_wb_ld_uns;
  logic [1:0]  ma_wb_ld_size;
  logic        rf_wr_en, rf_wr_rdy, fwd_hit, retire_pulse;
  logic [31:0] rf_wr_data, fwd_data, instret;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wen;
    int          addr;
    logic [31:0] data;
  } ment_t;

  ment_t       q[$];
  logic [31:0] instret_m = '0;

  always #5 clk = ~clk;

  wb_retire_stage #(
    .XLEN(32), .NREG(16), .RA_IDX(15), .DEPTH(DEPTH), .ZERO_REG_EN(1), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ma_wb_vld(ma_wb_vld), .ma_wb_rdy(ma_wb_rdy), .ma_wb_pc(ma_wb_pc), .ma_wb_rd(ma_wb_rd),
    .ma_wb_alu_result(ma_wb_alu_result), .ma_wb_ld_data(ma_wb_ld_data),
    .ma_wb_is_wb(ma_wb_is_wb), .ma_wb_is_ld(ma_wb_is_ld), .ma_wb_is_call(ma_wb_is_call),
    .ma_wb_ld_size(ma_wb_ld_size), .ma_wb_ld_uns(ma_wb_ld_uns),
    .rf_wr_en(rf_wr_en), .rf_wr_rdy(rf_wr_rdy), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .fwd_q_addr(fwd_q_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .retire_pulse(retire_pulse), .instret(instret)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] off, input logic [31:0] raw);
    logic [31:0] v;
    int bits;
    case (sz)
      2'd0:    begin v = (raw >> (8 * off)) & 32'hFF;      bits = 8;  end
      2'd1:    begin v = (raw >> (16 * off[1])) & 32'hFFFF; bits = 16; end
      default: begin v = raw;                               bits = 32; end
    endcase
    if (!uns && bits < 32 && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
    return v;
  endfunction

  function automatic ment_t mk_entry();
    ment_t e;
    e.addr = ma_wb_is_call ? 15 : int'(ma_wb_rd);
    e.wen  = (ma_wb_is_wb || ma_wb_is_call) && (e.addr != 0);
    if (ma_wb_is_call)    e.data = ma_wb_pc + 32'd4;
    else if (ma_wb_is_ld) e.data = ld_model(ma_wb_ld_size, ma_wb_ld_uns, ma_wb_alu_result[1:0], ma_wb_ld_data);
    else                  e.data = ma_wb_alu_result;
    return e;
  endfunction

  // One clock: compare every output against the model, then advance the model across the edge.
  task automatic tick();
    ment_t       h;
    bit          exp_pop, exp_acc, fh;
    logic [31:0] fd;
    #2;
    h       = '{wen: 1'b0, addr: 0, data: '0};
    exp_pop = 1'b0;
    fh      = 1'b0;
    fd      = '0;
    exp_acc = !rst && start && ma_wb_vld && (q.size() < DEPTH);
    if (!rst && q.size() > 0) begin
      h       = q[0];
      exp_pop = !h.wen || rf_wr_rdy;
    end
    if (!rst)
      for (int i = q.size() - 1; i >= 0; i--)
        if (!fh && q[i].wen && q[i].addr == int'(fwd_q_addr)) begin
          fh = 1'b1;
          fd = q[i].data;
        end
    chk("ma_wb_rdy", ma_wb_rdy, start && (q.size() < DEPTH));
    chk("rf_wr_en", rf_wr_en, h.wen);
    chk("rf_wr_addr", rf_wr_addr, h.addr);
    chk("rf_wr_data", rf_wr_data, h.data);
    chk("retire_pulse", retire_pulse, exp_pop);
    chk("fwd_hit", fwd_hit, fh);
    chk("fwd_data", fwd_data, fd);
    chk("instret", instret, rst ? 32'd0 : instret_m);
    @(posedge clk);
    if (rst) begin
      q.delete();
      instret_m = '0;
    end else begin
      if (exp_pop) begin
        void'(q.pop_front());
        instret_m = instret_m + 32'd1;
      end
      if (exp_acc) q.push_back(mk_entry());
    end
    #1;
  endtask

  task automatic drive(input bit vld, input bit wb, input bit ld, input bit call, input logic [3:0] rd,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] ldd,
                       input logic [1:0] sz, input bit uns);
    ma_wb_vld = vld; ma_wb_is_wb = wb; ma_wb_is_ld = ld; ma_wb_is_call = call; ma_wb_rd = rd;
    ma_wb_pc = pc; ma_wb_alu_result = alu; ma_wb_ld_data = ldd; ma_wb_ld_size = sz; ma_wb_ld_uns = uns;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0, 2'd0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rf_wr_rdy = 1'b0; fwd_q_addr = '0;
    idle();
    #1;
    chk("rst_rdy_no_start", ma_wb_rdy, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst_instret", instret, 32'd0);
    chk("post_rst_wr_en", rf_wr_en, 1'b0);

    // call: RA gets pc+4 one cycle later
    start = 1'b1; rf_wr_rdy = 1'b1;
    drive(1, 0, 0, 1, 4'd3, 32'h100, 32'h0, 32'h0, 2'd0, 0);
    tick(); idle();
    chk("call_wr_en", rf_wr_en, 1'b1);
    chk("call_addr", rf_wr_addr, 4'd15);
    chk("call_data", rf_wr_data, 32'h104);
    chk("call_retire", retire_pulse, 1'b1);
    tick();
    chk("call_instret", instret, 32'd1);

    // load formatting
    drive(1, 1, 1, 0, 4'd3, 32'h0, 32'h1003, 32'h80FF_FF00, 2'd0, 0);
    tick(); idle();
    chk("lb_off3_s", rf_wr_data, 32'hFFFF_FF80);
    tick();
    drive(1, 1, 1, 0, 4'd3, 32'h0, 32'h1003, 32'h80FF_FF00, 2'd0, 1);
    tick(); idle();
    chk("lb_off3_u", rf_wr_data, 32'h0000_0080);
    tick();
    drive(1, 1, 1, 0, 4'd3, 32'h0, 32'h2002, 32'h80FF_FF00, 2'd1, 0);
    tick(); idle();
    chk("lh_off2_s", rf_wr_data, 32'hFFFF_80FF);
    tick();

    // backpressure: third entry stalls until space frees
    rf_wr_rdy = 1'b0;
    drive(1, 1, 0, 0, 4'd1, 32'h0, 32'hA1, 32'h0, 2'd0, 0); tick();
    drive(1, 1, 0, 0, 4'd2, 32'h0, 32'hA2, 32'h0, 2'd0, 0); tick();
    chk("full_rdy", ma_wb_rdy, 1'b0);
    drive(1, 1, 0, 0, 4'd3, 32'h0, 32'hA3, 32'h0, 2'd0, 0); tick();
    chk("stall_head", rf_wr_data, 32'hA1);
    chk("stall_no_retire", retire_pulse, 1'b0);
    rf_wr_rdy = 1'b1;
    tick(); tick(); idle(); tick();
    chk("drain_instret", instret, 32'd7);

    // forwarding picks the youngest write
    rf_wr_rdy = 1'b0;
    drive(1, 1, 0, 0, 4'd5, 32'h0, 32'h11, 32'h0, 2'd0, 0); tick();
    drive(1, 1, 0, 0, 4'd5, 32'h0, 32'h22, 32'h0, 2'd0, 0); tick();
    idle();
    fwd_q_addr = 4'd5; #1;
    chk("fwd_r5_hit", fwd_hit, 1'b1);
    chk("fwd_r5_data", fwd_data, 32'h22);
    fwd_q_addr = 4'd6; #1;
    chk("fwd_r6_hit", fwd_hit, 1'b0);
    rf_wr_rdy = 1'b1;
    tick(); tick();

    // r0 suppression and non-writing entries still retire
    rf_wr_rdy = 1'b0;
    drive(1, 1, 0, 0, 4'd0, 32'h0, 32'h55, 32'h0, 2'd0, 0); tick(); idle();
    chk("r0_no_write", rf_wr_en, 1'b0);
    chk("r0_retire", retire_pulse, 1'b1);
    tick();
    drive(1, 0, 0, 0, 4'd7, 32'h0, 32'h66, 32'h0, 2'd0, 0); tick(); idle();
    chk("nowb_no_write", rf_wr_en, 1'b0);
    chk("nowb_retire", retire_pulse, 1'b1);
    tick();
    chk("nowb_instret", instret, 32'd11);

    // reset discards buffered writes
    drive(1, 1, 0, 0, 4'd1, 32'h0, 32'hB1, 32'h0, 2'd0, 0); tick();
    drive(1, 1, 0, 0, 4'd2, 32'h0, 32'hB2, 32'h0, 2'd0, 0); tick();
    idle();
    rst = 1'b1; #1;
    chk("rst_no_write", rf_wr_en, 1'b0);
    tick();
    rst = 1'b0; #1;
    chk("rst_instret", instret, 32'd0);
    chk("rst_empty", rf_wr_en, 1'b0);
    chk("rst_rdy", ma_wb_rdy, 1'b1);

    // start low: no accepts, buffered entry still drains
    drive(1, 1, 0, 0, 4'd4, 32'h0, 32'hC4, 32'h0, 2'd0, 0); tick();
    idle();
    start = 1'b0; #1;
    chk("stop_rdy", ma_wb_rdy, 1'b0);
    chk("stop_pending", rf_wr_en, 1'b1);
    rf_wr_rdy = 1'b1;
    tick();
    chk("stop_drained", instret, 32'd1);
    chk("stop_empty", rf_wr_en, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst              = ($urandom_range(0, 99) == 0);
      start            = ($urandom_range(0, 9) != 0);
      rf_wr_rdy        = ($urandom_range(0, 2) != 0);
      ma_wb_vld        = ($urandom_range(0, 4) < 3);
      ma_wb_is_call    = ($urandom_range(0, 7) == 0);
      ma_wb_is_ld      = ($urandom_range(0, 2) == 0);
      ma_wb_is_wb      = ($urandom_range(0, 3) != 0);
      ma_wb_rd         = 4'($urandom_range(0, 4));
      ma_wb_pc         = $urandom;
      ma_wb_alu_result = $urandom;
      ma_wb_ld_data    = $urandom;
      ma_wb_ld_size    = 2'($urandom_range(0, 3));
      ma_wb_ld_uns     = 1'($urandom_range(0, 1));
      fwd_q_addr       = ($urandom_range(0, 5) == 5) ? 4'd15 : 4'($urandom_range(0, 4));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_retire_stage.md
Name: wb_retire_stage

Overview:
- Parametrised next-generation writeback stage. Accepts completed instructions from the MA stage over a valid/ready handshake and formats load data by size, sign and byte offset.
- Buffers pending register writes in a small in-order retire FIFO and drains them to the register-file write port under rf_wr_rdy backpressure.
- Exposes youngest-match forwarding of buffered writes and an instructions-retired counter.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
NREG, 16, architectural register count; AW = clog2(NREG).
RA_IDX, NREG-1, return-address register written by calls.
DEPTH, 2, retire FIFO entries; legal range 1..8.
ZERO_REG_EN, 0, if 1 then writes to register 0 are suppressed (instruction still retires).
CNT_W, 32, retired-instruction counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  global run enable
ma_wb_vld  in  1  MA entry valid
ma_wb_rdy  out  1  stage can accept an entry
ma_wb_pc  in  XLEN  instruction PC
ma_wb_rd  in  AW  destination register from the instruction
ma_wb_alu_result  in  XLEN  ALU result; low 2 bits are the load byte offset
ma_wb_ld_data  in  XLEN  raw memory read word
ma_wb_is_wb  in  1  instruction writes a register
ma_wb_is_ld  in  1  load instruction
ma_wb_is_call  in  1  call instruction
ma_wb_ld_size  in  2  00 byte, 01 half, 10 word, 11 dword (XLEN=64 only)
ma_wb_ld_uns  in  1  zero-extend the load
rf_wr_en  out  1  register-file write strobe
rf_wr_rdy  in  1  register file accepts the write this cycle
rf_wr_addr  out  AW  write address
rf_wr_data  out  XLEN  write data
fwd_q_addr  in  AW  forwarding query address
fwd_hit  out  1  a buffered write targets fwd_q_addr
fwd_data  out  XLEN  data of the youngest matching buffered write
retire_pulse  out  1  one instruction retired this cycle
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: FIFO emptied; instret=0. All outputs 0 except ma_wb_rdy, which follows its combinational equation and is 0 while start=0.
- ma_wb_rdy = start && (count < DEPTH). No same-cycle pass-through when full.
- Enqueue on ma_wb_vld && ma_wb_rdy. Entry fields are computed at enqueue:
  - wen = is_wb || is_call, then cleared if ZERO_REG_EN && addr==0.
  - addr = is_call ? RA_IDX : ma_wb_rd.
  - data: is_call -> pc+4 (mod 2^XLEN); else is_ld -> aligned load; else alu_result. is_call has priority over is_ld.
- Load alignment (off = alu_result[1:0]):
  - byte: bits [8*off+7 : 8*off].
  - half: bits [16*off[1]+15 : 16*off[1]]; off[0] ignored.
  - word: bits [31:0].
  - dword: full XLEN. When XLEN=32, size 11 is treated as word.
  - Result is sign-extended to XLEN unless ld_uns=1, then zero-extended.
- Head entry is presented combinationally from FIFO registers. Minimum latency is 1 cycle: an entry accepted in cycle N can write in cycle N+1.
  - rf_wr_en = !empty && head.wen; rf_wr_addr and rf_wr_data = head fields. Both are 0 when empty.
  - Pop when (!empty && !head.wen) or (rf_wr_en && rf_wr_rdy). A non-writing entry pops without asserting rf_wr_en.
  - retire_pulse = pop. instret increments on pop and wraps at 2^CNT_W.
- Push and pop in the same cycle leave count unchanged. Push is legal when count==DEPTH-1 even if a pop also occurs. Pointers wrap modulo DEPTH.
- Forwarding is combinational across valid entries with wen=1 and addr==fwd_q_addr. The youngest match wins. fwd_hit=0 and fwd_data=0 when there is no match.
- start deasserted mid-operation: no new accepts, but buffered entries keep draining because they are architecturally committed.
- rst asserted mid-operation: all buffered entries are discarded in that cycle and no write is issued.

Decomposition:
- cpu_pkg additions:
  - wb_ld_size_e enum.
  - wb_entry_t struct {wen, addr, data}.
  - WB_RA_IDX_DEFAULT constant.
- One combinational sub-module, wb_ld_align (size, uns, off, raw -> XLEN data). It is reused by future load paths.
- The FIFO and counter stay inline.

Test Plan:
- Call at pc=0x100, rf_wr_rdy=1 -> next cycle rf_wr_en=1, addr=15, data=0x104; retire_pulse=1; instret=1.
- Load byte, off=3, ld_data=0x80FF_FF00, uns=0 -> data 0xFFFF_FF80; with uns=1 -> 0x0000_0080. Half, off=2 -> 0xFFFF_80FF.
- rf_wr_rdy=0 with DEPTH=2, push 3 ALU writes -> ma_wb_rdy drops after 2. Raise rdy -> writes drain in order, one per cycle, and instret=3.
- Two buffered writes to r5 (0x11 then 0x22), fwd_q_addr=5 -> fwd_hit=1, fwd_data=0x22. Query r6 -> fwd_hit=0.
- ZERO_REG_EN=1, ALU write to r0 -> no rf_wr_en, retire_pulse=1. An is_wb=0 entry also retires with no write.
- Two entries buffered with rf_wr_rdy=0, assert rst one cycle -> no write issued, instret=0, FIFO empty. Deassert start -> ma_wb_rdy=0 while a buffered entry still drains.
